tree_node_bank: RTL and testbench

Parametrised, writable multi-tree node store for the decision-tree inference path. It holds TREE_COUNT independent trees of TREE_DEPTH nodes each and replaces the per-tree fixed ROMs, so trees can be reloaded at run time through a write port. Reads use a valid/ready request port and a valid/ready response port with one-cycle latency and backpressure. A clear sequencer zeroes the whole store after reset, and can zero a single tree on command.

---
 rtl/tree_node_bank.sv | 179 +++++++++++++++++
 tb/tb_tree_node_bank.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_node_bank.sv
// tree_node_bank: writable node store holding TREE_COUNT trees of TREE_DEPTH
// words each. The read port uses valid/ready request and response handshakes
// with one cycle of latency. A clear sequencer zeroes the whole store after
// reset (INIT) and can zero a single tree on command (CLR).
module tree_node_bank #(
  parameter int NODE_WIDTH = 120,
  parameter int ADDR_WIDTH = 10,
  parameter int TREE_DEPTH = 512,
  parameter int TREE_COUNT = 16,
  parameter int TID_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [TID_WIDTH-1:0]  wr_tree,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [NODE_WIDTH-1:0] wr_data,
  output logic                  wr_drop,
  input  logic                  clr_start,
  input  logic [TID_WIDTH-1:0]  clr_tree,
  output logic                  busy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [TID_WIDTH-1:0]  req_tree,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [NODE_WIDTH-1:0] rsp_data,
  output logic                  rsp_oor
);

  localparam int DEPTH_BITS = $clog2(TREE_DEPTH);
  localparam int PA_WIDTH   = TID_WIDTH + DEPTH_BITS;
  localparam int TOTAL      = TREE_COUNT * TREE_DEPTH;

  localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH + 1)'(TREE_DEPTH);
  localparam logic [PA_WIDTH-1:0]   INIT_LAST  = PA_WIDTH'(TOTAL - 1);
  localparam logic [PA_WIDTH-1:0]   CLR_LAST   = PA_WIDTH'(TREE_DEPTH - 1);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_CLR  = 2'd2;

  // Node storage: no reset, INIT sweeps it to zero instead.
  logic [NODE_WIDTH-1:0] mem [TOTAL];

  logic [1:0]            state_reg;
  logic [PA_WIDTH-1:0]   cnt_reg;
  logic [TID_WIDTH-1:0]  clr_tree_reg;
  logic                  wr_drop_reg;
  logic                  rsp_valid_reg;
  logic [NODE_WIDTH-1:0] rsp_data_reg;
  logic                  rsp_oor_reg;

  logic                  idle;
  logic                  clr_accept;
  logic                  wr_oor;
  logic                  req_oor;
  logic                  req_fire;
  logic [PA_WIDTH-1:0]   wr_pa;
  logic [PA_WIDTH-1:0]   req_pa;
  logic                  mem_we;
  logic [PA_WIDTH-1:0]   mem_waddr;
  logic [NODE_WIDTH-1:0] mem_wdata;

  assign idle       = (state_reg == ST_IDLE);
  assign busy       = !idle;
  assign clr_accept = idle & clr_start;

  // Tree id forms the upper physical address bits because TREE_DEPTH is a power of two.
  assign wr_pa   = {wr_tree, wr_addr[DEPTH_BITS-1:0]};
  assign req_pa  = {req_tree, req_addr[DEPTH_BITS-1:0]};
  assign wr_oor  = ({1'b0, wr_addr} >= ADDR_LIMIT);
  assign req_oor = ({1'b0, req_addr} >= ADDR_LIMIT);

  assign req_ready = idle & (!rsp_valid_reg | rsp_ready);
  assign req_fire  = req_valid & req_ready;

  // Sequencer: INIT sweeps every word, CLR sweeps one tree, IDLE serves traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_INIT;
      cnt_reg      <= '0;
      clr_tree_reg <= '0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          if (cnt_reg == INIT_LAST) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + PA_WIDTH'(1);
          end
        end
        ST_IDLE: begin
          if (clr_start) begin
            state_reg    <= ST_CLR;
            cnt_reg      <= '0;
            clr_tree_reg <= clr_tree;
          end
        end
        ST_CLR: begin
          if (cnt_reg == CLR_LAST) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + PA_WIDTH'(1);
          end
        end
        default: begin
          state_reg <= ST_INIT;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Single write port: sequencer zero-fill while busy, user writes only in IDLE.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_pa;
    mem_wdata = wr_data;
    case (state_reg)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_reg;
        mem_wdata = '0;
      end
      ST_CLR: begin
        mem_we    = 1'b1;
        mem_waddr = {clr_tree_reg, cnt_reg[DEPTH_BITS-1:0]};
        mem_wdata = '0;
      end
      ST_IDLE: begin
        mem_we = wr_en & !wr_oor & !clr_start;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // Memory write; reads below sample the pre-write word (read-first).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Flag every write that was not committed, one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_drop_reg <= 1'b0;
    end else begin
      wr_drop_reg <= wr_en & (busy | wr_oor | clr_accept);
    end
  end

  // Response register: load on acceptance, hold under backpressure, drop when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_oor_reg   <= 1'b0;
    end else if (req_fire) begin
      rsp_valid_reg <= 1'b1;
      rsp_oor_reg   <= req_oor;
      rsp_data_reg  <= req_oor ? '0 : mem[req_pa];
    end else if (rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign wr_drop   = wr_drop_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_oor   = rsp_oor_reg;

endmodule

// File: tb/tb_tree_node_bank.sv
// Testbench for tree_node_bank: randomized writes/reads against an array model
// of the store, plus directed handshake, clear and reset scenarios.
module tb_tree_node_bank;

  localparam int NW = 120;
  localparam int AW = 4;
  localparam int TD = 8;
  localparam int TC = 4;
  localparam int TW = 2;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [TW-1:0] wr_tree;
  logic [AW-1:0] wr_addr;
  logic [NW-1:0] wr_data;
  logic          wr_drop;
  logic          clr_start;
  logic [TW-1:0] clr_tree;
  logic          busy;
  logic          req_valid;
  logic          req_ready;
  logic [TW-1:0] req_tree;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [NW-1:0] rsp_data;
  logic          rsp_oor;

  int errors = 0;
  int checks = 0;

  // Reference store: model[tree][node]
  logic [NW-1:0] model [TC][TD];

  tree_node_bank #(
    .NODE_WIDTH(NW), .ADDR_WIDTH(AW), .TREE_DEPTH(TD), .TREE_COUNT(TC), .TID_WIDTH(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_tree(wr_tree), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
    .clr_start(clr_start), .clr_tree(clr_tree), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_tree(req_tree), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_oor(rsp_oor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [NW-1:0] rand_word();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    w[0] = 1'b1;
    return w[NW-1:0];
  endfunction

  // Expected read result: zero beyond the tree, otherwise the stored word.
  function automatic logic [NW-1:0] ref_read(input int t, input int a);
    if (a >= TD) return '0;
    return model[t][a % TD];
  endfunction

  task automatic model_zero_all();
    for (int t = 0; t < TC; t++)
      for (int a = 0; a < TD; a++)
        model[t][a] = '0;
  endtask

  // One write cycle; returns the wr_drop value seen the following cycle.
  task automatic do_write(input int t, input int a, input logic [NW-1:0] d, output logic drop);
    wr_en = 1'b1; wr_tree = TW'(t); wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    drop = wr_drop;
    $display("wr  tree=%0d addr=%0d drop=%0b", t, a, drop);
  endtask

  // One read with rsp_ready high; ok is low if never accepted or no response appeared.
  task automatic do_read(input int t, input int a, output logic [NW-1:0] d, output logic o,
                         output bit ok);
    int w;
    w = 0;
    req_valid = 1'b1; req_tree = TW'(t); req_addr = AW'(a);
    while (!req_ready && w < 50) begin
      tick();
      w++;
    end
    tick();
    ok = (w < 50) && rsp_valid;
    d = rsp_data;
    o = rsp_oor;
    req_valid = 1'b0;
    $display("rd  tree=%0d addr=%0d data=%h oor=%0b", t, a, d, o);
  endtask

  task automatic test_reset();
    int n;
    logic [NW-1:0] d;
    logic o;
    bit ok;
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_oor !== 1'b0 || wr_drop !== 1'b0 ||
        busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got valid=%b data=%h oor=%b drop=%b busy=%b ready=%b, need 0 0 0 0 1 0",
               rsp_valid, rsp_data, rsp_oor, wr_drop, busy, req_ready);
    end
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== TC * TD) begin
      errors++;
      $display("FAIL init_busy_len: got %0d cycles, need %0d", n, TC * TD);
    end
    model_zero_all();
    do_read(2, 5, d, o, ok);
    checks++;
    if (!ok || d !== '0 || o !== 1'b0) begin
      errors++;
      $display("FAIL init_read: got ok=%b data=%h oor=%b, need ok=1 data=0 oor=0", ok, d, o);
    end
  endtask

  task automatic test_random();
    logic drop;
    logic [NW-1:0] d;
    logic o;
    bit ok;
    int t, a;
    for (int i = 0; i < 24; i++) begin
      t = int'($urandom_range(0, TC - 1));
      a = int'($urandom_range(0, 11));
      d = rand_word();
      do_write(t, a, d, drop);
      checks++;
      if (drop !== (a >= TD)) begin
        errors++;
        $display("FAIL rand_wr_drop: tree=%0d addr=%0d got %b need %b", t, a, drop, a >= TD);
      end
      if (a < TD) model[t][a] = d;
    end
    for (int i = 0; i < 40; i++) begin
      t = int'($urandom_range(0, TC - 1));
      a = int'($urandom_range(0, 15));
      do_read(t, a, d, o, ok);
      checks++;
      if (!ok || d !== ref_read(t, a) || o !== (a >= TD)) begin
        errors++;
        $display("FAIL rand_read: tree=%0d addr=%0d got ok=%b data=%h oor=%b need data=%h oor=%b",
                 t, a, ok, d, o, ref_read(t, a), a >= TD);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic drop;
    logic [NW-1:0] w0, w1;
    w0 = 120'h000140681000000000000000000023;
    w1 = 120'h1;
    do_write(0, 0, w0, drop); model[0][0] = w0;
    do_write(3, 7, w1, drop); model[3][7] = w1;
    req_valid = 1'b1; req_tree = 2'd0; req_addr = 4'd0;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b need 1", req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== w0) begin
      errors++;
      $display("FAIL b2b_first: got valid=%b data=%h need 1 %h", rsp_valid, rsp_data, w0);
    end
    req_tree = 2'd3; req_addr = 4'd7;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== w1) begin
      errors++;
      $display("FAIL b2b_second: got valid=%b data=%h need 1 %h", rsp_valid, rsp_data, w1);
    end
    req_valid = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got valid=%b need 0", rsp_valid);
    end
    $display("b2b words %h %h", w0, w1);
  endtask

  task automatic test_read_first();
    logic [NW-1:0] old_w, new_w;
    old_w = model[0][0];
    new_w = rand_word();
    wr_en = 1'b1; wr_tree = 2'd0; wr_addr = 4'd0; wr_data = new_w;
    req_valid = 1'b1; req_tree = 2'd0; req_addr = 4'd0;
    tick();
    wr_en = 1'b0;
    model[0][0] = new_w;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== old_w) begin
      errors++;
      $display("FAIL read_first: got valid=%b data=%h need 1 %h", rsp_valid, rsp_data, old_w);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== new_w) begin
      errors++;
      $display("FAIL wr_visibility: got valid=%b data=%h need 1 %h", rsp_valid, rsp_data, new_w);
    end
    $display("read-first old=%h new=%h", old_w, new_w);
    tick();
  endtask

  task automatic test_backpressure();
    logic drop;
    logic [NW-1:0] w [3];
    for (int a = 0; a < 3; a++) begin
      w[a] = rand_word();
      do_write(1, a, w[a], drop);
      model[1][a] = w[a];
    end
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_tree = 2'd1; req_addr = 4'd0;
    tick();
    req_addr = 4'd1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== w[0] || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b need 1 %h 0",
                 c, rsp_valid, rsp_data, req_ready, w[0]);
      end
      if (c < 2) tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== w[1]) begin
      errors++;
      $display("FAIL bp_word1: got valid=%b data=%h need 1 %h", rsp_valid, rsp_data, w[1]);
    end
    req_addr = 4'd2;
    tick();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== w[2]) begin
      errors++;
      $display("FAIL bp_word2: got valid=%b data=%h need 1 %h", rsp_valid, rsp_data, w[2]);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_dup: got valid=%b need 0", rsp_valid);
    end
    $display("backpressure words %h %h %h", w[0], w[1], w[2]);
  endtask

  task automatic test_oor();
    logic drop;
    logic [NW-1:0] d;
    logic o;
    bit ok;
    d = rand_word();
    do_write(1, 1, d, drop); model[1][1] = d;
    do_read(1, 9, d, o, ok);
    checks++;
    if (!ok || o !== 1'b1 || d !== '0) begin
      errors++;
      $display("FAIL oor_read: got ok=%b oor=%b data=%h need 1 1 0", ok, o, d);
    end
    do_write(2, 12, rand_word(), drop);
    checks++;
    if (drop !== 1'b1) begin
      errors++;
      $display("FAIL oor_wr_drop: got %b need 1", drop);
    end
    tick();
    checks++;
    if (wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL oor_drop_pulse: got %b need 0", wr_drop);
    end
    do_read(2, 4, d, o, ok);
    checks++;
    if (!ok || d !== model[2][4]) begin
      errors++;
      $display("FAIL oor_unchanged: got ok=%b data=%h need %h", ok, d, model[2][4]);
    end
  endtask

  task automatic test_clear();
    logic drop;
    logic [NW-1:0] d, pre;
    logic o;
    bit ok;
    int n, g;
    for (int t = 1; t <= 2; t++)
      for (int a = 0; a < TD; a++) begin
        d = rand_word();
        do_write(t, a, d, drop);
        model[t][a] = d;
      end
    pre = model[1][3];
    clr_start = 1'b1; clr_tree = 2'd1;
    req_valid = 1'b1; req_tree = 2'd1; req_addr = 4'd3;
    wr_en = 1'b1; wr_tree = 2'd2; wr_addr = 4'd0; wr_data = rand_word();
    tick();
    clr_start = 1'b0; req_valid = 1'b0; wr_en = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== pre) begin
      errors++;
      $display("FAIL clr_preclear_read: got valid=%b data=%h need 1 %h", rsp_valid, rsp_data, pre);
    end
    checks++;
    if (wr_drop !== 1'b1) begin
      errors++;
      $display("FAIL clr_coincident_drop: got %b need 1", wr_drop);
    end
    n = busy ? 1 : 0;
    wr_en = 1'b1; wr_tree = 2'd2; wr_addr = 4'd5; wr_data = rand_word();
    tick();
    wr_en = 1'b0;
    checks++;
    if (wr_drop !== 1'b1) begin
      errors++;
      $display("FAIL clr_busy_drop: got %b need 1", wr_drop);
    end
    if (busy) n++;
    g = 0;
    while (busy && g < 50) begin
      tick();
      g++;
      if (busy) n++;
    end
    checks++;
    if (n !== TD) begin
      errors++;
      $display("FAIL clr_busy_len: got %0d cycles, need %0d", n, TD);
    end
    for (int a = 0; a < TD; a++) model[1][a] = '0;
    for (int t = 1; t <= 2; t++)
      for (int a = 0; a < TD; a++) begin
        do_read(t, a, d, o, ok);
        checks++;
        if (!ok || d !== model[t][a]) begin
          errors++;
          $display("FAIL clr_contents: tree=%0d addr=%0d got ok=%b data=%h need %h",
                   t, a, ok, d, model[t][a]);
        end
      end
  endtask

  task automatic test_reset_mid_clear();
    logic drop;
    logic [NW-1:0] d, pre;
    logic o;
    bit ok;
    int n;
    for (int a = 0; a < TD; a++) begin
      d = rand_word();
      do_write(3, a, d, drop);
      model[3][a] = d;
    end
    pre = model[3][2];
    rsp_ready = 1'b0;
    clr_start = 1'b1; clr_tree = 2'd3;
    req_valid = 1'b1; req_tree = 2'd3; req_addr = 4'd2;
    tick();
    clr_start = 1'b0; req_valid = 1'b0;
    tick();
    wr_en = 1'b1; wr_tree = 2'd0; wr_addr = 4'd1; wr_data = rand_word();
    tick();
    wr_en = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== pre || wr_drop !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_clr_pre: got valid=%b data=%h drop=%b busy=%b need 1 %h 1 1",
               rsp_valid, rsp_data, wr_drop, busy, pre);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_oor !== 1'b0 || wr_drop !== 1'b0 ||
        busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_clr_reset: got valid=%b data=%h oor=%b drop=%b busy=%b ready=%b, need 0 0 0 0 1 0",
               rsp_valid, rsp_data, rsp_oor, wr_drop, busy, req_ready);
    end
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== TC * TD) begin
      errors++;
      $display("FAIL mid_clr_init_len: got %0d cycles, need %0d", n, TC * TD);
    end
    model_zero_all();
    for (int t = 0; t < TC; t++)
      for (int a = 0; a < TD; a++) begin
        do_read(t, a, d, o, ok);
        checks++;
        if (!ok || d !== model[t][a]) begin
          errors++;
          $display("FAIL mid_clr_zero: tree=%0d addr=%0d got ok=%b data=%h need 0", t, a, ok, d);
        end
      end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_tree = '0; wr_addr = '0; wr_data = '0;
    clr_start = 1'b0; clr_tree = '0;
    req_valid = 1'b0; req_tree = '0; req_addr = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_random();
    test_back_to_back();
    test_read_first();
    test_backpressure();
    test_oor();
    test_clear();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
